// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver: collects WIDTH qualified bits into a word and
// offers it on a registered valid/ready port, flagging words dropped for lack of ready.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sh_reg;
  logic [WIDTH-1:0] sh_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] par_out_reg;
  logic             par_valid_reg;
  logic             overrun_reg;
  logic             complete;
  logic             accept;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sh_next = {sh_reg[WIDTH-2:0], ser_in};
    end else begin : g_lsb_first
      assign sh_next = {ser_in, sh_reg[WIDTH-1:1]};
    end
  endgenerate

  assign complete = ser_valid && (cnt_reg == LAST);
  assign accept   = par_valid_reg && par_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_reg        <= '0;
      cnt_reg       <= '0;
      par_out_reg   <= '0;
      par_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else if (clear) begin
      // par_out deliberately holds its last word across an abort
      sh_reg        <= '0;
      cnt_reg       <= '0;
      par_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (ser_valid) begin
        sh_reg  <= sh_next;
        cnt_reg <= complete ? '0 : cnt_reg + 1'b1;
      end
      if (complete) begin
        // A word completing on an accept edge replaces the consumed one directly
        if (!par_valid_reg || par_ready) begin
          par_out_reg   <= sh_next;
          par_valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (accept) begin
        par_valid_reg <= 1'b0;
      end
    end
  end

  assign par_out   = par_out_reg;
  assign par_valid = par_valid_reg;
  assign overrun   = overrun_reg;
  assign busy      = (cnt_reg != '0);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: one MSB-first and one LSB-first instance
// share the same serial stimulus; each status is {par_valid, busy, overrun, par_out}.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ser_in;
  logic       ser_valid;
  logic       clear;
  logic       par_ready;
  logic [3:0] po_m, po_l;
  logic       pv_m, pv_l, busy_m, busy_l, ov_m, ov_l;
  logic [6:0] st_m, st_l;
  int         checks = 0;
  int         errors = 0;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid), .clear(clear),
    .par_out(po_m), .par_valid(pv_m), .par_ready(par_ready), .busy(busy_m), .overrun(ov_m)
  );

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid), .clear(clear),
    .par_out(po_l), .par_valid(pv_l), .par_ready(par_ready), .busy(busy_l), .overrun(ov_l)
  );

  assign st_m = {pv_m, busy_m, ov_m, po_m};
  assign st_l = {pv_l, busy_l, ov_l, po_l};

  always #5 clk = ~clk;

  // One qualified bit; consecutive calls keep ser_valid high at every edge.
  task automatic send_bit(input logic b);
    ser_in    = b;
    ser_valid = 1'b1;
    @(posedge clk);
    #1;
    ser_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    ser_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (st_m !== 7'b000_0000) begin errors++; $display("FAIL reset_msb got %b want %b", st_m, 7'b000_0000); end
    checks++;
    if (st_l !== 7'b000_0000) begin errors++; $display("FAIL reset_lsb got %b want %b", st_l, 7'b000_0000); end
    rst_n = 1'b1;
    idle(1);
    checks++;
    if (st_m !== 7'b000_0000) begin errors++; $display("FAIL reset_idle got %b want %b", st_m, 7'b000_0000); end
  endtask

  task automatic test_msb_first;
    logic [3:0] bits;
    logic [6:0] exp_st;
    bits = 4'b1001;
    par_ready = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      send_bit(bits[i]);
      exp_st = (i != 0) ? 7'b010_0000 : 7'b100_1001;
      checks++;
      if (st_m !== exp_st) begin errors++; $display("FAIL msb_bit%0d got %b want %b", 3 - i, st_m, exp_st); end
    end
    par_ready = 1'b1;
    idle(1);
    par_ready = 1'b0;
    checks++;
    if (st_m !== 7'b000_1001) begin errors++; $display("FAIL msb_accept got %b want %b", st_m, 7'b000_1001); end
  endtask

  task automatic test_lsb_first(input int gap);
    logic [3:0] bits;
    bits = 4'b1011;  // sent left to right: 1,0,1,1
    par_ready = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      send_bit(bits[i]);
      if (gap > 0 && i != 0) begin
        idle(gap);
        checks++;
        if (busy_l !== 1'b1 || pv_l !== 1'b0) begin
          errors++; $display("FAIL lsb_gap_hold busy %b valid %b want busy 1 valid 0", busy_l, pv_l);
        end
      end
    end
    checks++;
    if (st_l !== 7'b100_1101) begin errors++; $display("FAIL lsb_word gap%0d got %b want %b", gap, st_l, 7'b100_1101); end
    checks++;
    if (st_m !== 7'b100_1011) begin errors++; $display("FAIL lsb_msbref gap%0d got %b want %b", gap, st_m, 7'b100_1011); end
    par_ready = 1'b1;
    idle(1);
    par_ready = 1'b0;
    checks++;
    if (pv_l !== 1'b0) begin errors++; $display("FAIL lsb_accept valid %b want 0", pv_l); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bits;
    bits = 8'b1001_0110;
    par_ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      send_bit(bits[i]);
      if (i == 4) begin
        checks++;
        if (st_m !== 7'b100_1001) begin errors++; $display("FAIL b2b_first got %b want %b", st_m, 7'b100_1001); end
      end else if (i == 3) begin
        checks++;
        if (st_m !== 7'b010_1001) begin errors++; $display("FAIL b2b_gone got %b want %b", st_m, 7'b010_1001); end
      end
    end
    checks++;
    if (st_m !== 7'b100_0110) begin errors++; $display("FAIL b2b_second got %b want %b", st_m, 7'b100_0110); end
    checks++;
    if (st_l !== 7'b100_0110) begin errors++; $display("FAIL b2b_lsb got %b want %b", st_l, 7'b100_0110); end
    idle(1);
    par_ready = 1'b0;
    checks++;
    if (st_m !== 7'b000_0110) begin errors++; $display("FAIL b2b_drain got %b want %b", st_m, 7'b000_0110); end
  endtask

  task automatic test_overrun;
    logic [7:0] bits;
    bits = 8'b1001_0011;
    par_ready = 1'b0;
    for (int i = 7; i >= 0; i--) send_bit(bits[i]);
    checks++;
    if (st_m !== 7'b101_1001) begin errors++; $display("FAIL ovr_set got %b want %b", st_m, 7'b101_1001); end
    par_ready = 1'b1;
    idle(1);
    par_ready = 1'b0;
    checks++;
    if (st_m !== 7'b001_1001) begin errors++; $display("FAIL ovr_accept got %b want %b", st_m, 7'b001_1001); end
    idle(3);
    checks++;
    if (ov_m !== 1'b1 || ov_l !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b%b want 11", ov_m, ov_l); end
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    checks++;
    if (st_m !== 7'b000_1001) begin errors++; $display("FAIL ovr_clear got %b want %b", st_m, 7'b000_1001); end
  endtask

  task automatic test_clear;
    logic [3:0] bits;
    par_ready = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    checks++;
    if (busy_m !== 1'b1) begin errors++; $display("FAIL clr_busy got %b want 1", busy_m); end
    // a qualified bit on the clear edge must be ignored
    clear = 1'b1;
    send_bit(1'b1);
    clear = 1'b0;
    checks++;
    if (st_m !== 7'b000_1001) begin errors++; $display("FAIL clr_abort got %b want %b", st_m, 7'b000_1001); end
    bits = 4'b0101;
    for (int i = 3; i >= 0; i--) send_bit(bits[i]);
    checks++;
    if (st_m !== 7'b100_0101) begin errors++; $display("FAIL clr_word got %b want %b", st_m, 7'b100_0101); end
    checks++;
    if (st_l !== 7'b100_1010) begin errors++; $display("FAIL clr_word_lsb got %b want %b", st_l, 7'b100_1010); end
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    checks++;
    if (st_m !== 7'b000_0101) begin errors++; $display("FAIL clr_pending got %b want %b", st_m, 7'b000_0101); end
  endtask

  task automatic test_async_reset;
    logic [3:0] bits;
    par_ready = 1'b0;
    bits = 4'b1010;
    for (int i = 3; i >= 0; i--) send_bit(bits[i]);
    send_bit(1'b1);
    send_bit(1'b1);
    checks++;
    if (st_m !== 7'b110_1010) begin errors++; $display("FAIL arst_pre got %b want %b", st_m, 7'b110_1010); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (st_m !== 7'b000_0000) begin errors++; $display("FAIL arst_msb got %b want %b", st_m, 7'b000_0000); end
    checks++;
    if (st_l !== 7'b000_0000) begin errors++; $display("FAIL arst_lsb got %b want %b", st_l, 7'b000_0000); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bits = 4'b0110;
    for (int i = 3; i >= 0; i--) send_bit(bits[i]);
    checks++;
    if (st_m !== 7'b100_0110) begin errors++; $display("FAIL arst_restart got %b want %b", st_m, 7'b100_0110); end
  endtask

  initial begin
    rst_n     = 1'b0;
    ser_in    = 1'b0;
    ser_valid = 1'b0;
    clear     = 1'b0;
    par_ready = 1'b0;
    test_reset;
    test_msb_first;
    test_lsb_first(0);
    test_lsb_first(3);
    test_back_to_back;
    test_overrun;
    test_clear;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
